// File: rtl/hit_resolver.sv
// hit_resolver: decides when an active attack frame connects with the
// opponent. It issues one-cycle stun pulses, tracks health and declares
// the round result.
module hit_resolver #(
  parameter int PLAYER_WIDTH = 64,
  parameter int I_RANGE      = 32,
  parameter int D_RANGE      = 48,
  parameter int MAX_HEALTH   = 3
) (
  input  logic       clk_60Hz,
  input  logic       reset,
  input  logic [9:0] player1_pos_x,
  input  logic [9:0] player2_pos_x,
  input  logic [3:0] player1_state,
  input  logic [3:0] player2_state,
  output logic [1:0] stunmode1,
  output logic [1:0] stunmode2,
  output logic [1:0] p1_health,
  output logic [1:0] p2_health,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [3:0]  ST_BACK  = 4'd2;
  localparam logic [3:0]  ST_N_ACT = 4'd4;
  localparam logic [3:0]  ST_D_ACT = 4'd7;
  localparam logic [10:0] PW       = 11'(PLAYER_WIDTH);
  localparam logic [10:0] I_R      = 11'(I_RANGE);
  localparam logic [10:0] D_R      = 11'(D_RANGE);
  localparam logic [1:0]  MAX_H    = 2'(MAX_HEALTH);

  // Index 0 is P1, index 1 is P2. A strike by attacker gi lands on 1-gi.
  logic [1:0][3:0] att_state;
  logic [1:0]      swinging;
  logic [1:0]      in_range;
  logic [1:0]      strike;
  logic [1:0]      blocked;
  logic [1:0]      consumed_reg;
  logic [1:0]      consumed_next;
  logic [1:0][1:0] stun_reg;
  logic [1:0][1:0] stun_next;
  logic [1:0][1:0] health_reg;
  logic [1:0][1:0] health_next;
  logic            game_over_reg;
  logic            game_over_next;
  logic [1:0]      winner_reg;
  logic [1:0]      winner_next;

  logic [10:0] front_sum;
  logic [10:0] gap;

  // P1 faces right, so its front edge is the left edge plus the body
  // width. Overlapping bodies count as a gap of zero.
  assign front_sum = {1'b0, player1_pos_x} + PW;
  assign gap = (front_sum >= {1'b0, player2_pos_x}) ? 11'd0
             : ({1'b0, player2_pos_x} - front_sum);

  assign att_state[0] = player1_state;
  assign att_state[1] = player2_state;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_att
      assign swinging[gi] = (att_state[gi] == ST_N_ACT) || (att_state[gi] == ST_D_ACT);
      assign in_range[gi] = ((att_state[gi] == ST_N_ACT) && (gap < I_R)) ||
                            ((att_state[gi] == ST_D_ACT) && (gap < D_R));
      // The consumed flag stops a long active window from striking twice.
      assign strike[gi]  = in_range[gi] && !consumed_reg[gi] && !game_over_reg;
      assign blocked[gi] = (att_state[1-gi] == ST_BACK);
      assign consumed_next[gi] = swinging[gi] && (consumed_reg[gi] || strike[gi]);
      assign stun_next[1-gi] = !strike[gi] ? 2'b00 : (blocked[gi] ? 2'b10 : 2'b01);
      assign health_next[1-gi] = (strike[gi] && !blocked[gi] && (health_reg[1-gi] != 2'd0))
                               ? (health_reg[1-gi] - 2'd1) : health_reg[1-gi];
    end
  endgenerate

  // Round end: latch the result the first time any health value reaches zero.
  always_comb begin
    game_over_next = game_over_reg;
    winner_next    = winner_reg;
    if (!game_over_reg && ((health_next[0] == 2'd0) || (health_next[1] == 2'd0))) begin
      game_over_next = 1'b1;
      winner_next    = {health_next[0] == 2'd0, health_next[1] == 2'd0};
    end
  end

  // State register. Reset wins over any strike on the same edge.
  always_ff @(posedge clk_60Hz) begin
    if (reset) begin
      stun_reg      <= '0;
      health_reg    <= {MAX_H, MAX_H};
      consumed_reg  <= '0;
      game_over_reg <= 1'b0;
      winner_reg    <= 2'b00;
    end else begin
      stun_reg      <= stun_next;
      health_reg    <= health_next;
      consumed_reg  <= consumed_next;
      game_over_reg <= game_over_next;
      winner_reg    <= winner_next;
    end
  end

  assign stunmode1 = stun_reg[0];
  assign stunmode2 = stun_reg[1];
  assign p1_health = health_reg[0];
  assign p2_health = health_reg[1];
  assign game_over = game_over_reg;
  assign winner    = winner_reg;

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: directed scenarios plus random play, checked every
// cycle against a behavioural model of the round rules.
module tb_hit_resolver;

  localparam int W  = 64;
  localparam int IR = 32;
  localparam int DR = 48;
  localparam int MH = 3;

  logic       clk_60Hz;
  logic       reset;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic [3:0] player1_state;
  logic [3:0] player2_state;
  logic [1:0] stunmode1;
  logic [1:0] stunmode2;
  logic [1:0] p1_health;
  logic [1:0] p2_health;
  logic       game_over;
  logic [1:0] winner;

  int vectors;
  int miscompares;

  // Model state
  int m_h1, m_h2, m_go, m_win, m_s1, m_s2;
  bit m_c1, m_c2;

  hit_resolver #(
    .PLAYER_WIDTH(W), .I_RANGE(IR), .D_RANGE(DR), .MAX_HEALTH(MH)
  ) dut (
    .clk_60Hz(clk_60Hz),
    .reset(reset),
    .player1_pos_x(player1_pos_x),
    .player2_pos_x(player2_pos_x),
    .player1_state(player1_state),
    .player2_state(player2_state),
    .stunmode1(stunmode1),
    .stunmode2(stunmode2),
    .p1_health(p1_health),
    .p2_health(p2_health),
    .game_over(game_over),
    .winner(winner)
  );

  initial clk_60Hz = 1'b0;
  always #5 clk_60Hz = ~clk_60Hz;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic step(input int a, input int b, input int s1, input int s2, input bit rst);
    int  gap;
    bit  r1, r2;
    player1_pos_x = 10'(a);
    player2_pos_x = 10'(b);
    player1_state = 4'(s1);
    player2_state = 4'(s2);
    reset         = rst;
    @(posedge clk_60Hz);
    if (rst) begin
      m_h1 = MH; m_h2 = MH; m_go = 0; m_win = 0; m_s1 = 0; m_s2 = 0;
      m_c1 = 0; m_c2 = 0;
    end else begin
      gap = b - (a + W);
      if (gap < 0) gap = 0;
      r1 = (((s1 == 4) && (gap < IR)) || ((s1 == 7) && (gap < DR))) && !m_c1 && (m_go == 0);
      r2 = (((s2 == 4) && (gap < IR)) || ((s2 == 7) && (gap < DR))) && !m_c2 && (m_go == 0);
      m_s2 = r1 ? ((s2 == 2) ? 2 : 1) : 0;
      m_s1 = r2 ? ((s1 == 2) ? 2 : 1) : 0;
      if (r1 && s2 != 2 && m_h2 > 0) m_h2 = m_h2 - 1;
      if (r2 && s1 != 2 && m_h1 > 0) m_h1 = m_h1 - 1;
      m_c1 = (s1 == 4 || s1 == 7) ? (m_c1 || r1) : 1'b0;
      m_c2 = (s2 == 4 || s2 == 7) ? (m_c2 || r2) : 1'b0;
      if (m_go == 0 && (m_h1 == 0 || m_h2 == 0)) begin
        m_go  = 1;
        m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : ((m_h2 == 0) ? 1 : 2);
      end
    end
    #1;
    chk("stunmode1", int'(stunmode1), m_s1);
    chk("stunmode2", int'(stunmode2), m_s2);
    chk("p1_health", int'(p1_health), m_h1);
    chk("p2_health", int'(p2_health), m_h2);
    chk("game_over", int'(game_over), m_go);
    chk("winner",    int'(winner),    m_win);
  endtask

  initial begin
    int a, b, s1, s2;
    bit rst;
    vectors = 0;
    miscompares = 0;
    m_h1 = MH; m_h2 = MH; m_go = 0; m_win = 0; m_s1 = 0; m_s2 = 0;
    m_c1 = 0; m_c2 = 0;

    // Reset state
    step(0, 500, 0, 0, 1);
    chk("reset_h1", int'(p1_health), 3);
    chk("reset_go", int'(game_over), 0);

    // Neutral hit at gap 16, held two cycles: exactly one pulse
    step(100, 180, 4, 0, 0);
    chk("n_hit_stun", int'(stunmode2), 1);
    chk("n_hit_h2", int'(p2_health), 2);
    step(100, 180, 4, 0, 0);
    chk("n_hit_pulse_end", int'(stunmode2), 0);
    step(100, 180, 0, 0, 0);

    // Blocked neutral strike
    step(0, 500, 0, 0, 1);
    step(100, 180, 4, 2, 0);
    chk("block_stun", int'(stunmode2), 2);
    chk("block_h2", int'(p2_health), 3);
    step(100, 180, 4, 2, 0);
    chk("block_pulse_end", int'(stunmode2), 0);
    step(100, 180, 0, 0, 0);

    // Gap 40: neutral misses, directional connects
    step(0, 500, 0, 0, 1);
    step(100, 204, 4, 0, 0);
    chk("gap40_neutral", int'(stunmode2), 0);
    step(100, 204, 0, 0, 0);
    step(100, 204, 7, 0, 0);
    chk("gap40_dir", int'(stunmode2), 1);
    step(100, 204, 0, 0, 0);

    // Trade at gap 0 with both players on 1 health
    step(0, 500, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(100, 164, 4, 0, 0);
      step(100, 164, 0, 0, 0);
      step(100, 164, 0, 7, 0);
      step(100, 164, 0, 0, 0);
    end
    chk("pre_trade_h1", int'(p1_health), 1);
    chk("pre_trade_h2", int'(p2_health), 1);
    step(100, 164, 4, 7, 0);
    chk("trade_s1", int'(stunmode1), 1);
    chk("trade_s2", int'(stunmode2), 1);
    chk("trade_go", int'(game_over), 1);
    chk("trade_win", int'(winner), 3);
    step(100, 164, 0, 0, 0);

    // P2 wins with three directional hits; a fourth is ignored
    step(0, 500, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(100, 174, 0, 7, 0);
      step(100, 174, 0, 0, 0);
    end
    chk("ko_h1", int'(p1_health), 0);
    chk("ko_win", int'(winner), 2);
    step(100, 174, 0, 7, 0);
    chk("post_ko_stun", int'(stunmode1), 0);
    step(100, 174, 0, 0, 0);

    // Reset on the same edge as a strike
    step(100, 180, 4, 0, 0);
    step(100, 180, 0, 0, 0);
    step(100, 180, 4, 0, 1);
    chk("rst_strike_s2", int'(stunmode2), 0);
    chk("rst_strike_h2", int'(p2_health), 3);
    chk("rst_strike_go", int'(game_over), 0);

    // Random play
    for (int i = 0; i < 400; i++) begin
      a   = int'($urandom_range(0, 700));
      b   = a + int'($urandom_range(0, 140));
      s1  = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4 : 7) : int'($urandom_range(0, 10));
      s2  = ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? 4 : 7) : int'($urandom_range(0, 10));
      rst = ($urandom_range(0, 39) == 0);
      step(a, b, s1, s2, rst);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 SHALL have parameter PLAYER_WIDTH, default 64, hurtbox width in pixels.
REQ-002 SHALL have parameter I_RANGE, default 32, neutral-attack reach in pixels beyond the attacker's front edge.
REQ-003 SHALL have parameter D_RANGE, default 48, directional-attack reach in pixels beyond the attacker's front edge.
REQ-004 SHALL have parameter MAX_HEALTH, default 3, starting health per player.
REQ-005 SHALL have port clk_60Hz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port player1_pos_x, input, 10 bits: P1 left edge; P1 is on the left and faces right.
REQ-008 SHALL have port player2_pos_x, input, 10 bits: P2 left edge; P2 is on the right and faces left.
REQ-009 SHALL have port player1_state, input, 4 bits: P1 controller state.
REQ-010 SHALL have port player2_state, input, 4 bits: P2 controller state.
REQ-011 SHALL have port stunmode1, output, 2 bits: stun command to P1 (00 none, 01 hitstun, 10 blockstun, 11 unused).
REQ-012 SHALL have port stunmode2, output, 2 bits: stun command to P2, same encoding as stunmode1.
REQ-013 SHALL have port p1_health, output, 2 bits: P1 remaining health.
REQ-014 SHALL have port p2_health, output, 2 bits: P2 remaining health.
REQ-015 SHALL have port game_over, output, 1 bit: round ended.
REQ-016 SHALL have port winner, output, 2 bits: 00 none, 01 P1, 10 P2, 11 draw.

Function
REQ-017 SHALL use the controller state encoding: 0 IDLE, 1 FORWARD, 2 BACKWARD, 3/4/5 neutral startup/active/recovery, 6/7/8 directional startup/active/recovery, 9 HITSTUN, 10 BLOCKSTUN.
REQ-018 SHALL compute gap = player2_pos_x − (player1_pos_x + PLAYER_WIDTH) in 11-bit arithmetic, and force gap to 0 when that sum ≥ player2_pos_x (overlap).
REQ-019 SHALL declare an attacker's strike in range when its state is 4 and gap < I_RANGE, or its state is 7 and gap < D_RANGE.
REQ-020 SHALL keep one consumed flag per attacker: set on the edge a strike registers; cleared on any edge where that attacker's state is neither 4 nor 7.
REQ-021 SHALL register a strike only when it is in range, the attacker's consumed flag is clear, and game_over is 0.
REQ-022 SHALL classify a registered strike as blocked (code 10) when the defender's state is 2 (BACKWARD), otherwise as a hit (code 01).
REQ-023 SHALL load the defender's stunmode register with the code on the edge the strike registers, making it visible for exactly one clock cycle, then return it to 00 (one cycle of latency, pulse width 1).
REQ-024 SHALL decrement the defender's health by 1 on a hit, saturating at 0, and SHALL NOT change health on a block.
REQ-025 SHALL process simultaneous strikes (trade) on the same edge independently: both stunmode outputs and both health values update in the same cycle.
REQ-026 SHALL set game_over on the edge a health value reaches 0; winner SHALL be 01 if only P2 reaches 0, 10 if only P1 reaches 0, and 11 if both reach 0 on the same edge.
REQ-027 SHALL, while game_over=1, hold stunmode1 and stunmode2 at 00 and freeze health and winner until reset.
REQ-028 SHALL treat attacker states 3, 5, 6 and 8 as never striking; a long active window (state 4 or 7 held for several cycles) SHALL yield exactly one strike.

Reset
REQ-029 SHALL, on a clk_60Hz edge with reset=1, set stunmode1=stunmode2=00, p1_health=p2_health=MAX_HEALTH, game_over=0, winner=00, and clear both consumed flags.
REQ-030 SHALL give reset priority over any same-edge strike, and a reset mid-round SHALL fully restart the round.

Verification
REQ-031 SHALL cover this scenario: P1 x=100, P2 x=180 (gap 16), P1 state 4 for 2 cycles, P2 state 0 -> stunmode2=01 for one cycle only, p2_health 3->2.
REQ-032 SHALL cover the same setup with P2 state 2 -> stunmode2=10 for one cycle, p2_health stays 3.
REQ-033 SHALL cover this scenario: P1 x=100, P2 x=204 (gap 40); P1 state 4 -> no stun; then P1 state 7 -> stunmode2=01.
REQ-034 SHALL cover a trade: P1 state 4, P2 state 7 on the same edge, gap 0, both health 1 -> stunmode1=stunmode2=01, both health 0, game_over=1, winner=11.
REQ-035 SHALL cover three separate P2 state-7 strikes on P1 at gap 10 -> p1_health 3->0, winner=10; a 4th strike afterward -> stunmode1 stays 00.
REQ-036 SHALL cover reset asserted on the same edge as a registered strike -> stunmode outputs 00, health 3/3, game_over=0.
